// File: rtl/spi_ram_slave_burst.sv
// SPI slave fronting a word-addressed scratch RAM: address/write/read frames,
// optional address post-increment for bursts, and a sticky out-of-range flag.
module spi_ram_slave_burst #(
    parameter int DATA_W    = 8,
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256,
    parameter int AUTO_INC  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ss_n,
    input  logic mosi,
    output logic miso,
    output logic err,
    output logic frame_done
);

    localparam int FRAME_W = DATA_W + 2;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [ADDR_SIZE:0]   DEPTH   = (ADDR_SIZE + 1)'(MEM_DEPTH);
    localparam logic [ADDR_SIZE-1:0] LAST    = ADDR_SIZE'(MEM_DEPTH - 1);
    localparam logic [CNT_W-1:0]     LAST_RX = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0]     LAST_TX = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]     TX_END  = CNT_W'(DATA_W);

    typedef enum logic [1:0] {IDLE, RX, TX_LOAD, TX} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [FRAME_W-2:0]     rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0]      tx_sr_q, tx_sr_d;
    logic [ADDR_SIZE-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0]   rd_addr_q, rd_addr_d;
    logic                   miso_d, err_d, frame_done_d;
    logic                   mem_we;
    logic [DATA_W-1:0]      mem [MEM_DEPTH];

    logic [FRAME_W-1:0]     frame;
    logic [1:0]             cmd;
    logic [DATA_W-1:0]      payload;
    logic [ADDR_SIZE-1:0]   frame_addr;

    function automatic logic in_range(input logic [ADDR_SIZE-1:0] a);
        return {1'b0, a} < DEPTH;
    endfunction

    // Wrap at the implemented depth rather than the full address space
    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
        if (AUTO_INC == 0)
            return a;
        else if (a == LAST)
            return '0;
        else
            return a + ADDR_SIZE'(1);
    endfunction

    assign frame      = {rx_sr_q, mosi};
    assign cmd        = frame[FRAME_W-1:FRAME_W-2];
    assign payload    = frame[DATA_W-1:0];
    assign frame_addr = payload[ADDR_SIZE-1:0];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rx_sr_d      = rx_sr_q;
        tx_sr_d      = tx_sr_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        miso_d       = 1'b0;
        err_d        = err;
        frame_done_d = 1'b0;
        mem_we       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!ss_n) begin
                    state_d = RX;
                    rx_sr_d = {rx_sr_q[FRAME_W-3:0], mosi};
                    cnt_d   = CNT_W'(1);
                end
            end
            RX: begin
                if (ss_n) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_RX) begin
                    // Decode on the last bit so the next frame can follow immediately
                    cnt_d = '0;
                    unique case (cmd)
                        2'b00: begin
                            wr_addr_d    = frame_addr;
                            err_d        = err | ~in_range(frame_addr);
                            frame_done_d = 1'b1;
                        end
                        2'b01: begin
                            mem_we       = in_range(wr_addr_q);
                            err_d        = err | ~in_range(wr_addr_q);
                            wr_addr_d    = next_addr(wr_addr_q);
                            frame_done_d = 1'b1;
                        end
                        2'b10: begin
                            rd_addr_d    = frame_addr;
                            err_d        = err | ~in_range(frame_addr);
                            frame_done_d = 1'b1;
                        end
                        default: state_d = TX_LOAD;
                    endcase
                end else begin
                    rx_sr_d = {rx_sr_q[FRAME_W-3:0], mosi};
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            TX_LOAD: begin
                if (ss_n) begin
                    state_d = IDLE;
                end else begin
                    tx_sr_d   = in_range(rd_addr_q) ? mem[rd_addr_q[IDX_W-1:0]] : '0;
                    err_d     = err | ~in_range(rd_addr_q);
                    rd_addr_d = next_addr(rd_addr_q);
                    state_d   = TX;
                end
                cnt_d = '0;
            end
            TX: begin
                if (ss_n) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == TX_END) begin
                    state_d = RX;
                    cnt_d   = '0;
                end else begin
                    miso_d       = tx_sr_q[DATA_W-1];
                    tx_sr_d      = {tx_sr_q[DATA_W-2:0], 1'b0};
                    cnt_d        = cnt_q + CNT_W'(1);
                    frame_done_d = (cnt_q == LAST_TX);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rx_sr_q    <= '0;
            tx_sr_q    <= '0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            miso       <= 1'b0;
            err        <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_sr_q    <= rx_sr_d;
            tx_sr_q    <= tx_sr_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            miso       <= miso_d;
            err        <= err_d;
            frame_done <= frame_done_d;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive rst_n
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wr_addr_q[IDX_W-1:0]] <= payload;
    end

endmodule

// File: tb/tb_spi_ram_slave_burst.sv
// Drives three parameter variants with shared SPI traffic and checks each
// against a frame-level model of the memory, address registers and error flag.
module tb_spi_ram_slave_burst;

    localparam int FW = 10;

    logic       clk = 1'b0;
    logic       rst_n, ss_n, mosi;
    logic [2:0] miso_v, err_v, fd_v;

    always #5 clk = ~clk;

    spi_ram_slave_burst #(.DATA_W(8), .ADDR_SIZE(8), .MEM_DEPTH(256), .AUTO_INC(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .ss_n(ss_n), .mosi(mosi),
        .miso(miso_v[0]), .err(err_v[0]), .frame_done(fd_v[0]));

    spi_ram_slave_burst #(.DATA_W(8), .ADDR_SIZE(8), .MEM_DEPTH(256), .AUTO_INC(0)) u_noinc (
        .clk(clk), .rst_n(rst_n), .ss_n(ss_n), .mosi(mosi),
        .miso(miso_v[1]), .err(err_v[1]), .frame_done(fd_v[1]));

    spi_ram_slave_burst #(.DATA_W(8), .ADDR_SIZE(8), .MEM_DEPTH(200), .AUTO_INC(1)) u_d200 (
        .clk(clk), .rst_n(rst_n), .ss_n(ss_n), .mosi(mosi),
        .miso(miso_v[2]), .err(err_v[2]), .frame_done(fd_v[2]));

    int         m_depth [3] = '{256, 256, 200};
    bit         m_inc   [3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0] m_mem   [3][256];
    logic [7:0] m_wr [3], m_rd [3];
    logic       m_err [3];
    logic       exp_miso [3], exp_fd [3];
    logic [7:0] rd_model [3], rd_dut [3];

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    task automatic checkOutput(input string name, input int idx, input logic [31:0] act,
                               input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("[TB] FAIL %s[%0d] at %0t: got %0h expected %0h", name, idx, $time, act, expv);
        end
    endtask

    function automatic logic [7:0] inc_addr(input int i, input logic [7:0] a);
        if (!m_inc[i]) return a;
        if (int'(a) == m_depth[i] - 1) return 8'h00;
        return a + 8'd1;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                checkOutput("miso", i, 32'(miso_v[i]), 32'(exp_miso[i]));
                checkOutput("frame_done", i, 32'(fd_v[i]), 32'(exp_fd[i]));
                checkOutput("err", i, 32'(err_v[i]), 32'(m_err[i]));
            end
        end
    end

    task automatic set_quiet();
        for (int i = 0; i < 3; i++) begin
            exp_miso[i] = 1'b0;
            exp_fd[i]   = 1'b0;
        end
    endtask

    task automatic tick(input logic ss, input logic b);
        @(negedge clk);
        ss_n = ss;
        mosi = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        ss_n = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("rst_miso", i, 32'(miso_v[i]), 32'd0);
            checkOutput("rst_err", i, 32'(err_v[i]), 32'd0);
            checkOutput("rst_fd", i, 32'(fd_v[i]), 32'd0);
            m_wr[i]  = 8'h00;
            m_rd[i]  = 8'h00;
            m_err[i] = 1'b0;
        end
        set_quiet();
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic apply_cmd(input int i, input logic [1:0] cmd, input logic [7:0] p);
        case (cmd)
            2'b00: begin
                m_wr[i] = p;
                if (int'(p) >= m_depth[i]) m_err[i] = 1'b1;
            end
            2'b01: begin
                if (int'(m_wr[i]) < m_depth[i]) m_mem[i][m_wr[i]] = p;
                else m_err[i] = 1'b1;
                m_wr[i] = inc_addr(i, m_wr[i]);
            end
            default: begin
                m_rd[i] = p;
                if (int'(p) >= m_depth[i]) m_err[i] = 1'b1;
            end
        endcase
    endtask

    // abort_at: posedge index at which the frame is cut (-1 = never); use_reset picks rst_n over ss_n
    task automatic applyStimulus(input logic [1:0] cmd, input logic [7:0] payload,
                                 input int abort_at, input bit use_reset);
        logic [9:0] fr;
        int         last;
        int         k;
        fr   = {cmd, payload};
        last = (cmd == 2'b11) ? 19 : 9;
        for (int s = 0; s <= last; s++) begin
            if (s == abort_at) begin
                if (use_reset) do_reset();
                else begin
                    tick(1'b1, 1'($urandom));
                    set_quiet();
                end
                return;
            end
            tick(1'b0, (s < FW) ? fr[FW-1-s] : 1'($urandom));
            set_quiet();
            if (s == 9 && cmd != 2'b11) begin
                for (int i = 0; i < 3; i++) begin
                    apply_cmd(i, cmd, payload);
                    exp_fd[i] = 1'b1;
                end
            end else if (s == 10) begin
                for (int i = 0; i < 3; i++) begin
                    if (int'(m_rd[i]) < m_depth[i]) rd_model[i] = m_mem[i][m_rd[i]];
                    else begin
                        rd_model[i] = 8'h00;
                        m_err[i]    = 1'b1;
                    end
                    m_rd[i] = inc_addr(i, m_rd[i]);
                end
            end else if (s >= 11 && s <= 18) begin
                k = s - 10;
                for (int i = 0; i < 3; i++) begin
                    exp_miso[i]        = rd_model[i][8-k];
                    exp_fd[i]          = (k == 8);
                    rd_dut[i][8-k]     = miso_v[i];
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int       cmd_r, last, ab;
        logic [7:0] p;
        rst_n = 1'b0;
        ss_n  = 1'b1;
        mosi  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_wr[i] = 8'h00; m_rd[i] = 8'h00; m_err[i] = 1'b0;
            rd_model[i] = 8'h00; rd_dut[i] = 8'h00;
        end
        set_quiet();
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("init_miso", i, 32'(miso_v[i]), 32'd0);
            checkOutput("init_err", i, 32'(err_v[i]), 32'd0);
            checkOutput("init_fd", i, 32'(fd_v[i]), 32'd0);
        end
        #20 rst_n = 1'b1;
        chk_en = 1'b1;

        $display("[TB] filling memories");
        for (int a = 0; a < 256; a++) begin
            applyStimulus(2'b00, 8'(a), -1, 1'b0);
            applyStimulus(2'b01, 8'($urandom), -1, 1'b0);
        end
        do_reset();

        $display("[TB] basic write/read");
        applyStimulus(2'b00, 8'h10, -1, 1'b0);
        applyStimulus(2'b01, 8'hA5, -1, 1'b0);
        applyStimulus(2'b10, 8'h10, -1, 1'b0);
        applyStimulus(2'b11, 8'h00, -1, 1'b0);
        checkOutput("t1_read", 0, 32'(rd_dut[0]), 32'hA5);
        checkOutput("t1_model", 0, 32'(rd_model[0]), 32'hA5);
        checkOutput("t1_err", 0, 32'(err_v[0]), 32'd0);

        $display("[TB] burst with wrap");
        applyStimulus(2'b00, 8'hFE, -1, 1'b0);
        applyStimulus(2'b01, 8'h11, -1, 1'b0);
        applyStimulus(2'b01, 8'h22, -1, 1'b0);
        applyStimulus(2'b01, 8'h33, -1, 1'b0);
        applyStimulus(2'b10, 8'hFE, -1, 1'b0);
        applyStimulus(2'b11, 8'h00, -1, 1'b0);
        checkOutput("t2_rd0", 0, 32'(rd_dut[0]), 32'h11);
        applyStimulus(2'b11, 8'h00, -1, 1'b0);
        checkOutput("t2_rd1", 0, 32'(rd_dut[0]), 32'h22);
        applyStimulus(2'b11, 8'h00, -1, 1'b0);
        checkOutput("t2_rd2", 0, 32'(rd_dut[0]), 32'h33);
        applyStimulus(2'b10, 8'h00, -1, 1'b0);
        applyStimulus(2'b11, 8'h00, -1, 1'b0);
        checkOutput("t2_mem0", 0, 32'(rd_dut[0]), 32'h33);

        $display("[TB] address hold without auto-increment");
        applyStimulus(2'b00, 8'h05, -1, 1'b0);
        applyStimulus(2'b01, 8'h01, -1, 1'b0);
        applyStimulus(2'b01, 8'h02, -1, 1'b0);
        applyStimulus(2'b10, 8'h05, -1, 1'b0);
        applyStimulus(2'b11, 8'h00, -1, 1'b0);
        checkOutput("t3_rd0", 1, 32'(rd_dut[1]), 32'h02);
        applyStimulus(2'b11, 8'h00, -1, 1'b0);
        checkOutput("t3_rd1", 1, 32'(rd_dut[1]), 32'h02);

        $display("[TB] out-of-range on reduced depth");
        do_reset();
        applyStimulus(2'b00, 8'hC8, -1, 1'b0);
        checkOutput("t4_err_set", 2, 32'(err_v[2]), 32'd1);
        checkOutput("t4_err_full", 0, 32'(err_v[0]), 32'd0);
        applyStimulus(2'b01, 8'h77, -1, 1'b0);
        applyStimulus(2'b10, 8'hC8, -1, 1'b0);
        applyStimulus(2'b11, 8'h00, -1, 1'b0);
        checkOutput("t4_read_zero", 2, 32'(rd_dut[2]), 32'h00);
        checkOutput("t4_err_sticky", 2, 32'(err_v[2]), 32'd1);

        $display("[TB] partial frame discard");
        applyStimulus(2'b00, 8'h20, -1, 1'b0);
        applyStimulus(2'b01, 8'h00, -1, 1'b0);
        applyStimulus(2'b00, 8'h20, -1, 1'b0);
        applyStimulus(2'b01, 8'h5A, 5, 1'b0);
        applyStimulus(2'b10, 8'h20, -1, 1'b0);
        applyStimulus(2'b11, 8'h00, -1, 1'b0);
        checkOutput("t5_untouched", 0, 32'(rd_dut[0]), 32'h00);

        $display("[TB] reset during transmit");
        applyStimulus(2'b00, 8'h07, -1, 1'b0);
        applyStimulus(2'b01, 8'hC3, -1, 1'b0);
        applyStimulus(2'b10, 8'h07, -1, 1'b0);
        applyStimulus(2'b11, 8'h00, 14, 1'b1);
        applyStimulus(2'b11, 8'h00, -1, 1'b0);
        applyStimulus(2'b10, 8'h07, -1, 1'b0);
        applyStimulus(2'b11, 8'h00, -1, 1'b0);
        checkOutput("t6_retained", 0, 32'(rd_dut[0]), 32'hC3);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 250; n++) begin
            cmd_r = $urandom_range(0, 3);
            case ($urandom_range(0, 2))
                0:       p = 8'($urandom_range(250, 255));
                1:       p = 8'($urandom_range(195, 205));
                default: p = 8'($urandom);
            endcase
            last = (cmd_r == 3) ? 19 : 9;
            ab   = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, last)) : -1;
            if ($urandom_range(0, 60) == 0) do_reset();
            applyStimulus(2'(cmd_r), p, ab, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                tick(1'b1, 1'($urandom));
                set_quiet();
            end
        end
        tick(1'b1, 1'b0);
        set_quiet();
        tick(1'b1, 1'b0);
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_ram_slave_burst.md
Name: spi_ram_slave_burst

Overview:
- Parametrised SPI-slave-plus-RAM block; successor to the fixed 10-bit-frame / 8-bit-data SPI RAM wrapper.
- Generalises data width, address width and depth.
- Adds three behaviours the earlier block lacks: read/write address auto-increment for burst access, out-of-range address detection, and back-to-back frames within one SS_n assertion.
- Sits at chip top as the host-facing register/scratch memory port.

Parameters:
DATA_W, 8, data word width and frame payload width in bits (>= ADDR_SIZE)
ADDR_SIZE, 8, address width; address taken from payload[ADDR_SIZE-1:0]
MEM_DEPTH, 256, number of words implemented (1..2^ADDR_SIZE)
AUTO_INC, 1, 1 = post-increment address after each data write/read; 0 = address held

Ports:
clk  input  1  SPI/system clock; all sampling on posedge
rst_n  input  1  asynchronous, active-low reset
ss_n  input  1  slave select, active low
mosi  input  1  serial data in, MSB first
miso  output  1  serial data out, registered
err  output  1  sticky out-of-range flag
frame_done  output  1  one-cycle pulse when a frame's effect commits

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - miso=0, err=0, frame_done=0, state=IDLE.
  - wr_addr=0, rd_addr=0, bit counter=0.
  - Memory contents are not reset.
- Frame format: FRAME_W = 2+DATA_W bits, MSB first.
  - Bits [FRAME_W-1:FRAME_W-2] = cmd; remaining bits = payload.
- States: IDLE, RX, TX_LOAD, TX.
- IDLE -> RX on a posedge with ss_n=0; that same posedge samples frame bit FRAME_W-1.
- RX: samples mosi on each posedge with ss_n=0. On the posedge sampling bit 0 (call it posedge n), the frame is decoded in the same cycle:
  - cmd 00: wr_addr <= payload[ADDR_SIZE-1:0].
  - cmd 01: mem[wr_addr] <= payload[DATA_W-1:0]; wr_addr increments if AUTO_INC.
  - cmd 10: rd_addr <= payload[ADDR_SIZE-1:0].
  - cmd 11: payload is ignored; next state TX_LOAD.
  - All other cmds stay in RX with the counter cleared, so back-to-back frames are allowed.
- frame_done pulses high for the cycle after posedge n for cmds 00/01/10. For cmd 11 it pulses the cycle after the last TX bit.
- TX_LOAD (posedge n+1): tx_sr <= mem[rd_addr]; rd_addr increments if AUTO_INC.
- TX: at posedge n+1+k (k=1..DATA_W), miso <= tx_sr bit DATA_W-k. mosi is ignored during TX_LOAD/TX.
  - After posedge n+1+DATA_W, the next posedge returns to RX. miso returns to 0 on that posedge.
- Auto-increment wraps MEM_DEPTH-1 -> 0.
- Out-of-range (address >= MEM_DEPTH):
  - cmd 00/10 with an out-of-range payload address: the address register is loaded anyway and err is set.
  - Write to an out-of-range wr_addr: no memory update; err set.
  - Read from an out-of-range rd_addr: tx_sr loads 0; err set.
  - err clears only on reset.
- ss_n=1 at any posedge in RX/TX_LOAD/TX:
  - Go to IDLE and discard the partial frame: no memory or address update, no frame_done.
  - miso <= 0; any in-progress read increment already committed in TX_LOAD stands.
- miso is 0 in every state except TX.
- Reset asserted mid-frame: immediate return to reset values; memory retains prior contents.
- Width: payload bits above ADDR_SIZE are ignored for cmd 00/10. The counter is sized $clog2(FRAME_W+1).

Test Plan:
- Defaults; frames 00_0x10, 01_0xA5, 10_0x10, 11_xx -> MISO shifts 1010_0101 on posedges n+2..n+9; frame_done pulses 4 times; err=0.
- Burst, single ss_n low: 00_0xFE, 01_0x11, 01_0x22, 01_0x33; then 10_0xFE and three 11 frames -> reads return 0x11, 0x22, 0x33; address wraps FE->FF->00; mem[0x00]=0x33.
- AUTO_INC=0: 00_0x05, 01_0x01, 01_0x02, then read of 0x05 twice -> both reads return 0x02.
- MEM_DEPTH=200: write 0xC8 with data 0x77 -> err=1, no memory change; read 0xC8 -> MISO all 0; err stays 1 until rst_n pulse.
- ss_n raised after 5 bits of 01_0x5A to address 0x20 (previously 0x00) -> mem[0x20] stays 0x00; no frame_done; state IDLE; next full frame decodes correctly.
- rst_n asserted during TX bit 3 -> miso=0, err=0, wr_addr=rd_addr=0 immediately; a prior write to 0x07 is still readable after reset.
